// File: rtl/axis_lr_line_arbiter.sv
// Left/right line-interleaving AXI-Stream arbiter with a common frame-start lock.
// Define LR_ARB_STATS_EN to add the frame_count and err_count outputs.
module axis_lr_line_arbiter #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int LINES_PER_FRAME  = 480
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_l_tdata,
  input  logic                        s_axis_l_tvalid,
  input  logic                        s_axis_l_tlast,
  input  logic                        s_axis_l_tuser,
  output logic                        s_axis_l_tready,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_r_tdata,
  input  logic                        s_axis_r_tvalid,
  input  logic                        s_axis_r_tlast,
  input  logic                        s_axis_r_tuser,
  output logic                        s_axis_r_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
  output logic                        m_axis_tlast,
  output logic                        m_axis_tuser,
  output logic                        m_axis_tid,
  input  logic                        m_axis_tready,
`ifdef LR_ARB_STATS_EN
  output logic [15:0]                 frame_count,
  output logic [7:0]                  err_count,
`endif
  output logic                        sync_err
);

  typedef enum logic [1:0] {
    ST_SYNC,
    ST_L,
    ST_R
  } state_t;

  localparam logic [15:0] LAST_LINE = 16'(LINES_PER_FRAME - 1);

  state_t                        r_state;
  state_t                        w_next;
  logic [15:0]                   r_line_cnt;
  logic                          r_first;
  logic                          r_tvalid;
  logic [AXIS_TDATA_WIDTH-1:0]   r_tdata;
  logic                          r_tlast;
  logic                          r_tuser;
  logic                          r_tid;
  logic                          r_sync_err;

  logic                          w_slot;
  logic                          w_side;
  logic                          w_line;
  logic                          w_g_valid;
  logic                          w_g_user;
  logic                          w_g_last;
  logic [AXIS_TDATA_WIDTH-1:0]   w_g_data;
  logic                          w_exp;
  logic                          w_g_rdy;
  logic                          w_take;
  logic                          w_err;
  logic                          w_fwd;
  logic                          w_eol;
  logic                          w_wrap;
  logic                          w_l_held;
  logic                          w_r_held;
  logic                          w_l_rdy;
  logic                          w_r_rdy;

  assign w_slot    = ~r_tvalid | m_axis_tready;
  assign w_side    = (r_state == ST_R);
  assign w_line    = (r_state != ST_SYNC);
  assign w_g_valid = w_side ? s_axis_r_tvalid : s_axis_l_tvalid;
  assign w_g_user  = w_side ? s_axis_r_tuser  : s_axis_l_tuser;
  assign w_g_last  = w_side ? s_axis_r_tlast  : s_axis_l_tlast;
  assign w_g_data  = w_side ? s_axis_r_tdata  : s_axis_l_tdata;
  assign w_l_held  = s_axis_l_tvalid & s_axis_l_tuser;
  assign w_r_held  = s_axis_r_tvalid & s_axis_r_tuser;

  // tuser is only legal on the first beat of each side's line 0
  assign w_exp   = r_first & (r_line_cnt == '0);
  // an unexpected frame start is refused so it can seed the next lock
  assign w_g_rdy = w_slot & ~(w_g_user & ~w_exp);
  assign w_take  = w_line & w_g_valid & w_g_rdy;
  assign w_err   = w_line & w_g_valid & w_slot & (w_g_user ^ w_exp);
  assign w_fwd   = w_take & ~w_err;
  assign w_eol   = w_fwd & w_g_last;
  assign w_wrap  = w_eol & w_side & (r_line_cnt == LAST_LINE);

  always_comb begin
    w_next  = r_state;
    w_l_rdy = 1'b0;
    w_r_rdy = 1'b0;
    unique case (r_state)
      ST_SYNC: begin
        w_l_rdy = ~w_l_held;
        w_r_rdy = ~w_r_held;
        if (w_l_held && w_r_held) w_next = ST_L;
      end
      ST_L: begin
        w_l_rdy = w_g_rdy;
        if (w_err)      w_next = ST_SYNC;
        else if (w_eol) w_next = ST_R;
      end
      ST_R: begin
        w_r_rdy = w_g_rdy;
        if (w_err)      w_next = ST_SYNC;
        else if (w_eol) w_next = ST_L;
      end
      default: w_next = ST_SYNC;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state    <= ST_SYNC;
      r_line_cnt <= '0;
      r_first    <= 1'b1;
      r_sync_err <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_sync_err <= w_err;
      if (r_state == ST_SYNC || w_err)
        r_line_cnt <= '0;
      else if (w_eol && w_side)
        r_line_cnt <= w_wrap ? '0 : r_line_cnt + 16'd1;
      if (r_state == ST_SYNC)
        r_first <= 1'b1;
      else if (w_take)
        r_first <= w_g_last;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_tvalid <= 1'b0;
      r_tdata  <= '0;
      r_tlast  <= 1'b0;
      r_tuser  <= 1'b0;
      r_tid    <= 1'b0;
    end else if (w_fwd) begin
      r_tvalid <= 1'b1;
      r_tdata  <= w_g_data;
      r_tlast  <= w_g_last;
      r_tuser  <= w_g_user;
      r_tid    <= w_side;
    end else if (m_axis_tready) begin
      r_tvalid <= 1'b0;
    end
  end

`ifdef LR_ARB_STATS_EN
  logic [15:0] r_frame_cnt;
  logic [7:0]  r_err_cnt;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_frame_cnt <= '0;
      r_err_cnt   <= '0;
    end else begin
      if (w_wrap) r_frame_cnt <= r_frame_cnt + 16'd1;
      if (w_err && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign frame_count = r_frame_cnt;
  assign err_count   = r_err_cnt;
`endif

  // reset must silence the combinational SYNC discard path too
  assign s_axis_l_tready = w_l_rdy & aresetn;
  assign s_axis_r_tready = w_r_rdy & aresetn;
  assign m_axis_tvalid   = r_tvalid;
  assign m_axis_tdata    = r_tdata;
  assign m_axis_tlast    = r_tlast;
  assign m_axis_tuser    = r_tuser;
  assign m_axis_tid      = r_tid;
  assign sync_err        = r_sync_err;

endmodule

// File: doc/axis_lr_line_arbiter.md
# axis_lr_line_arbiter

Shares one AXI-Stream output between the left and right camera pixel streams of the stereovision pipeline. Lines are strictly interleaved: one complete left line, then one complete right line. The block locks both inputs to a common frame start (tuser) and detects loss of frame alignment. It sits upstream of the output synchroniser and feeds the single DMA/VDMA stream port.

## Interface
- AXIS_TDATA_WIDTH, 32: pixel beat width, both inputs and the output.
- LINES_PER_FRAME, 480: line pairs (L+R) per frame; range 2..65535.
- aclk  in  1  clock; all logic on rising edge.
- aresetn  in  1  asynchronous, active-low reset.
- s_axis_l_tdata  in  AXIS_TDATA_WIDTH  left pixel data.
- s_axis_l_tvalid / s_axis_l_tlast / s_axis_l_tuser  in  1 each  left valid, end of line, start of frame.
- s_axis_l_tready  out  1  left ready.
- s_axis_r_tdata / tvalid / tlast / tuser / tready: right stream, same widths and directions as the left stream.
- m_axis_tdata  out  AXIS_TDATA_WIDTH  forwarded pixel.
- m_axis_tvalid / m_axis_tlast / m_axis_tuser  out  1 each  output valid, end of line, start of frame.
- m_axis_tid  out  1  source of the current beat: 0 = left, 1 = right.
- m_axis_tready  in  1  downstream ready.
- sync_err  out  1  one-cycle pulse on a frame-alignment error.

## Operation
- There are three states: SYNC, L_LINE and R_LINE. Reset enters SYNC with line_cnt = 0.
- In SYNC, each input discards beats with tuser = 0: tready = 1, and the beat is not forwarded.
- In SYNC, an input presenting tvalid & tuser = 1 is held: its tready = 0.
- When both inputs are held in the same cycle, the next state is L_LINE.
- L_LINE grants left only. Right tready = 0.
- In L_LINE, an accepted left beat with tlast moves the state to R_LINE.
- R_LINE grants right only. Left tready = 0.
- In R_LINE, an accepted right beat with tlast increments line_cnt and moves the state to L_LINE.
- When line_cnt = LINES_PER_FRAME-1 at that point, line_cnt wraps to 0.
- Granted-side tready = !m_axis_tvalid | m_axis_tready.
- On acceptance, the beat is copied into the output register: tdata, tlast, tuser, and tid = granted side.
- Expected tuser is 1 on the first beat of each side's first line of a frame (line_cnt = 0), and 0 on every other beat.
- A granted tuser = 1 at an unexpected position is a mismatch. The beat is not accepted (tready = 0), sync_err pulses, and the state goes to SYNC. The held beat then becomes the new frame start.
- A granted tuser = 0 where 1 is expected is also a mismatch. The beat is consumed and dropped, sync_err pulses, and the state goes to SYNC.
- After a mismatch, the output line in flight ends without tlast. The downstream synchroniser repairs this; this block does not insert tlast.
- line_cnt is cleared on every entry to SYNC.

## Timing
- Reset values: m_axis_tvalid = 0, m_axis_tdata = 0, m_axis_tlast = 0, m_axis_tuser = 0, m_axis_tid = 0, sync_err = 0, both s tready = 0. The state is SYNC.
- Latency from input acceptance to m_axis_tvalid is 1 cycle.
- Sustained throughput is 1 beat/cycle within a line.
- Switching sides costs 0 bubble cycles: the first beat of the other side may be accepted in the cycle after the tlast acceptance.
- The output holds tdata/tlast/tuser/tid stable while tvalid & !tready.
- SYNC → L_LINE takes 1 cycle after both inputs are held.
- A tready that is 1 in SYNC combinationally depends on tvalid/tuser of the same input only.
- If aresetn is asserted mid-line, all outputs drop immediately to their reset values. The partial line is lost.
- If LINES_PER_FRAME is reached exactly on the last R tlast, the next L beat must carry tuser = 1.

## Configuration
- LR_ARB_STATS_EN defined: adds frame_count (out, 16) and err_count (out, 8).
- frame_count increments on every line_cnt wrap and wraps modulo 2^16.
- err_count increments on each sync_err pulse and saturates at 255.
- Both counters reset to 0.
- LR_ARB_STATS_EN undefined: these ports and counters are absent. All other behaviour is identical.

## Test plan
- Startup sync: after reset, L sends 3 beats with tuser = 0, then a tuser = 1 beat; R sends 5 beats with tuser = 0, then a tuser = 1 beat. Required: 8 beats discarded, no output; the first output beat is L's tuser beat with tid = 0 and m_axis_tuser = 1.
- Interleave: LINES_PER_FRAME = 2, 4-beat lines, m_axis_tready = 1. Required: output order L0, R0, L1, R1, then L0 of the next frame with tuser = 1; tlast on every 4th beat; no idle cycles.
- Backpressure: m_axis_tready toggles 1,0,0,1 during an L line. Required: data stable while stalled; no beat lost or duplicated; right tready = 0 throughout.
- Early tuser: R presents tuser = 1 at beat 2 of line 1. Required: sync_err = 1 for one cycle; R tready = 0 on that beat; state returns to SYNC; the next output is L's frame start.
- Missing tuser: L line 0 beat 0 arrives with tuser = 0. Required: the beat is dropped, sync_err pulses, and (with LR_ARB_STATS_EN) err_count = 1.
- Reset mid-line: aresetn = 0 during beat 3 of an L line. Required: m_axis_tvalid = 0 in the same cycle; on release, the state is SYNC and frame_count = 0.
